// File: rtl/modulator.sv
// Purpose : TDM 4-channel carrier modulator; multiplies gated burst samples by a per-channel 5-point carrier LUT.
// Latency : 2 enable cycles from input beat to output beat.
// Backpres: single pipeline enable (en = !m_axis_tvalid || m_axis_tready); stalls hold outputs, s_axis_tready = en.
//
// Ports:
//   s_axis_aclk / s_axis_aresetn     clock, async active-low reset
//   s_axis_tdata/tvalid/tready/tuser input sample stream (signed 24-bit in [23:0], channel index in tuser)
//   m_axis_tdata/tvalid/tready/tuser/tlast  modulated output stream, tlast marks last beat of a burst
//   start, burst_len                 burst request (length in 4-beat frames), sampled while idle
//   busy                             high while a burst is armed or transmitting
module modulator #(
  parameter int BURST_W = 16
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_aresetn,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [1:0]         s_axis_tuser,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [1:0]         m_axis_tuser,
  output logic               m_axis_tlast,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ARM, TX} state_t;

  state_t               state;
  logic [2:0]           phase [4];
  logic [BURST_W-1:0]   frame_cnt;
  logic [BURST_W-1:0]   burst_len_q;

  logic                 en;
  logic                 beat;
  logic                 gate;
  logic                 last_beat;
  logic [2:0]           cur_phase;

  // Stage 1 registers
  logic                 s1_vld;
  logic signed [23:0]   s1_x;
  logic signed [23:0]   s1_coef;
  logic [1:0]           s1_user;
  logic                 s1_gate;
  logic                 s1_last;

  logic signed [47:0]   prod;
  logic                 unused_bits;

  // Carrier table indexed by phase; phase steps by 2 mod 5 per burst beat.
  function automatic logic signed [23:0] carrier(input logic [2:0] p);
    case (p)
      3'd0:    carrier = 24'sd0;
      3'd1:    carrier = 24'sd7978040;
      3'd2:    carrier = 24'sd4930700;
      3'd3:    carrier = -24'sd4930700;
      3'd4:    carrier = -24'sd7978040;
      default: carrier = 24'sd0;
    endcase
  endfunction

  function automatic logic [2:0] phase_adv(input logic [2:0] p);
    phase_adv = (p >= 3'd3) ? (p - 3'd3) : (p + 3'd2);
  endfunction

  assign en            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = en;
  assign beat          = s_axis_tvalid && en;
  assign cur_phase     = phase[s_axis_tuser];
  assign busy          = (state != IDLE);

  // A beat belongs to the burst once in TX, or when it is the channel-0 beat that opens it.
  assign gate      = (state == TX) || ((state == ARM) && (s_axis_tuser == 2'd0));
  assign last_beat = (state == TX) && (s_axis_tuser == 2'd3) &&
                     ((frame_cnt + BURST_W'(1)) == burst_len_q);

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      burst_len_q <= '0;
      for (int i = 0; i < 4; i++) phase[i] <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (burst_len != '0)) begin
            burst_len_q <= burst_len;
            frame_cnt   <= '0;
            for (int i = 0; i < 4; i++) phase[i] <= 3'd0;
            state       <= ARM;
          end
        end
        ARM: begin
          if (beat && (s_axis_tuser == 2'd0)) begin
            phase[0] <= phase_adv(phase[0]);
            state    <= TX;
          end
        end
        TX: begin
          if (beat) begin
            phase[s_axis_tuser] <= phase_adv(cur_phase);
            if (s_axis_tuser == 2'd3) begin
              frame_cnt <= frame_cnt + BURST_W'(1);
              if (last_beat) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign prod = $signed({{24{s1_x[23]}}, s1_x}) * $signed({{24{s1_coef[23]}}, s1_coef});

  // Upper input byte and low product bits are discarded by design.
  assign unused_bits = ^{s_axis_tdata[31:24], prod[22:0]};

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      s1_vld        <= 1'b0;
      s1_x          <= '0;
      s1_coef       <= '0;
      s1_user       <= 2'd0;
      s1_gate       <= 1'b0;
      s1_last       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 2'd0;
      m_axis_tlast  <= 1'b0;
    end else if (en) begin
      s1_vld        <= s_axis_tvalid;
      s1_x          <= s_axis_tdata[23:0];
      s1_coef       <= carrier(cur_phase);
      s1_user       <= s_axis_tuser;
      s1_gate       <= s_axis_tvalid && gate;
      s1_last       <= s_axis_tvalid && last_beat;
      m_axis_tvalid <= s1_vld;
      // product >>> 23 fits in 25 bits; sign-extend to 32 (floor rounding)
      m_axis_tdata  <= s1_gate ? {{7{prod[47]}}, prod[47:23]} : 32'd0;
      m_axis_tuser  <= s1_user;
      m_axis_tlast  <= s1_last;
    end
  end

endmodule

// File: tb/tb_modulator.sv
module tb_modulator;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [1:0]    s_tuser = 2'd0;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [1:0]    m_tuser;
  logic          m_tlast;
  logic          start = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          busy;

  always #5 clk = ~clk;

  modulator #(.BURST_W(BW)) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .start         (start),
    .burst_len     (burst_len),
    .busy          (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef enum int {M_IDLE, M_ARM, M_TX} mst_t;
  typedef struct {
    logic [31:0] d;
    logic [1:0]  u;
    logic        l;
    logic        g;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ch0log[$];
  int          lut_v[5] = '{0, 7978040, 4930700, -4930700, -7978040};
  int          ref5[5]  = '{0, 587, -952, 951, -588};
  mst_t        m_state = M_IDLE;
  int          m_phase[4];
  int          m_fcnt = 0;
  int          m_blen = 0;
  int          ngated = 0;
  int          nlast  = 0;
  bit          acc_last = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic [1:0]  prev_u;
  logic        prev_l;

  // stimulus controls
  int ch = 0;
  bit const_x = 1'b1;
  bit vld_rand = 1'b0;
  bit rdy_rand = 1'b0;
  bit src_on = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_state = M_IDLE;
      m_fcnt = 0;
      m_blen = 0;
      for (int i = 0; i < 4; i++) m_phase[i] = 0;
      sb.delete();
      acc_last = 1'b0;
      prev_stall = 1'b0;
    end else begin
      automatic mst_t st0 = m_state;
      automatic bit acc = s_tvalid && s_tready;
      // output side
      if (prev_stall) begin
        check("stall_data", m_tdata, prev_d);
        check("stall_user", 32'(m_tuser), 32'(prev_u));
        check("stall_last", 32'(m_tlast), 32'(prev_l));
      end
      check("busy", 32'(busy), 32'(st0 != M_IDLE));
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(1), 32'(0));
        end else begin
          automatic exp_t e = sb.pop_front();
          check("data", m_tdata, e.d);
          check("user", 32'(m_tuser), 32'(e.u));
          check("last", 32'(m_tlast), 32'(e.l));
          if (e.g) ngated++;
          if (e.g && e.u == 2'd0) ch0log.push_back(m_tdata);
        end
        if (m_tlast) nlast++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_u = m_tuser;
      prev_l = m_tlast;
      // input side
      acc_last = acc;
      if (acc) begin
        automatic exp_t e;
        automatic int u = int'(s_tuser);
        automatic logic signed [23:0] xs = s_tdata[23:0];
        automatic longint p;
        e.u = s_tuser;
        e.l = 1'b0;
        e.d = 32'd0;
        e.g = (m_state == M_TX) || (m_state == M_ARM && u == 0);
        if (e.g) begin
          p = longint'(xs) * longint'(lut_v[m_phase[u]]);
          p = p >>> 23;
          e.d = p[31:0];
          m_phase[u] = (m_phase[u] + 2) % 5;
          if (m_state == M_ARM) begin
            m_state = M_TX;
          end else if (u == 3) begin
            m_fcnt++;
            if (m_fcnt == m_blen) begin
              e.l = 1'b1;
              m_state = M_IDLE;
            end
          end
        end
        sb.push_back(e);
      end
      if (st0 == M_IDLE && start && burst_len != '0) begin
        m_blen = int'(burst_len);
        m_fcnt = 0;
        for (int i = 0; i < 4; i++) m_phase[i] = 0;
        m_state = M_ARM;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] gen();
    logic [7:0] junk = 8'($urandom);
    if (const_x) return {junk, 24'd1000};
    return $urandom;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (acc_last || !s_tvalid) begin
      if (acc_last) ch = (ch + 1) % 4;
      s_tdata  = gen();
      s_tuser  = 2'(ch);
      s_tvalid = src_on && (vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
    m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic kick(input int len);
    step();
    start = 1'b1;
    burst_len = BW'(len);
  endtask

  task automatic wait_idle(input string tag);
    step();
    for (int i = 0; i < 400 && busy; i++) step();
    check(tag, 32'(busy), 32'(0));
  endtask

  task automatic settle();
    rdy_rand = 1'b0;
    repeat (6) step();
  endtask

  task automatic check_ch0(input string tag, input int n);
    check({tag, "_n"}, 32'(ch0log.size()), 32'(n));
    for (int i = 0; i < n && i < ch0log.size(); i++)
      check($sformatf("%s_%0d", tag, i), ch0log[i], ref5[i]);
  endtask

  initial begin
    automatic int g0;
    automatic int l0;
    // reset state
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'(0));
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) step();

    // constant x=1000, burst_len 2 then 5
    ch0log.delete();
    kick(2);
    wait_idle("b2_done");
    settle();
    check_ch0("b2_ch0", 2);
    ch0log.delete();
    kick(5);
    wait_idle("b5_done");
    settle();
    check_ch0("b5_ch0", 5);

    // start while channel-2 beat is presented
    for (int i = 0; i < 8 && s_tuser != 2'd2; i++) step();
    start = 1'b1;
    burst_len = BW'(3);
    step();
    check("mid_start_busy", 32'(busy), 32'(1));
    wait_idle("mid_start_done");
    settle();

    // burst_len 1: four gated beats, one tlast
    g0 = ngated;
    l0 = nlast;
    kick(1);
    wait_idle("b1_done");
    settle();
    check("b1_gated", 32'(ngated - g0), 32'(4));
    check("b1_tlast", 32'(nlast - l0), 32'(1));

    // zero-length start ignored
    kick(0);
    repeat (3) step();
    check("len0_busy", 32'(busy), 32'(0));

    // start while busy and burst_len changes after latch are ignored
    g0 = ngated;
    kick(3);
    repeat (3) step();
    start = 1'b1;
    burst_len = BW'(1);
    step();
    burst_len = BW'(7);
    wait_idle("busy_start_done");
    settle();
    check("busy_start_gated", 32'(ngated - g0), 32'(12));

    // random ready/valid, constant x: same ch0 sequence
    ch0log.delete();
    vld_rand = 1'b1;
    rdy_rand = 1'b1;
    kick(5);
    wait_idle("rnd_b5_done");
    settle();
    check_ch0("rnd_ch0", 5);

    // random data, random handshakes
    const_x = 1'b0;
    rdy_rand = 1'b1;
    kick(4);
    wait_idle("rnd_data_done");
    rdy_rand = 1'b1;
    kick(2);
    wait_idle("rnd_data2_done");
    settle();

    // reset during first TX frame of a 4-frame burst
    const_x = 1'b1;
    vld_rand = 1'b0;
    l0 = nlast;
    kick(4);
    for (int i = 0; i < 20 && m_state != M_TX; i++) step();
    step();
    check("pre_rst_busy", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", 32'(m_tvalid), 32'(0));
    check("arst_tdata", m_tdata, 32'd0);
    check("arst_tuser", 32'(m_tuser), 32'(0));
    check("arst_tlast", 32'(m_tlast), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    step();
    step();
    #2 rst_n = 1'b1;
    repeat (4) step();
    check("arst_no_tlast", 32'(nlast - l0), 32'(0));
    ch0log.delete();
    kick(2);
    wait_idle("post_rst_done");
    settle();
    check_ch0("post_rst_ch0", 2);

    // drain
    src_on = 1'b0;
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    check("drain", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/modulator.md
MODULATOR -- requirements
Module: modulator

Interface
REQ-001 SHALL have parameter BURST_W, default 16, width of burst-length field and frame counter.
REQ-002 SHALL have ports:
- s_axis_aclk  in  1  sole clock, all logic rising-edge.
- s_axis_aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  32  signed baseband sample; bits [23:0] used, [31:24] ignored.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  input sample accepted when high with tvalid.
- s_axis_tuser  in  2  channel index 0..3, TDM order 0,1,2,3.
- m_axis_tdata  out  32  signed modulated sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  2  channel index of output sample.
- m_axis_tlast  out  1  last sample of a burst.
- start  in  1  one-cycle burst request.
- burst_len  in  BURST_W  burst length in frames (4 channel beats each), sampled on accepted start.
- busy  out  1  high while state != IDLE.

Function
REQ-003 SHALL hold carrier LUT {0, 7978040, 4930700, -4930700, -7978040} (signed 24-bit), indexed by per-channel phase 0..4.
REQ-004 SHALL keep four 3-bit phase registers; on each accepted beat in TX, phase[tuser] <= (phase[tuser]+2) mod 5; index sequence per channel 0,2,4,1,3,0...
REQ-005 SHALL run FSM IDLE, ARM, TX.
REQ-006 IDLE: start high and burst_len != 0 -> latch burst_len, clear all phases, go ARM; start with burst_len == 0 ignored.
REQ-007 ARM: first accepted beat with tuser==0 -> go TX; that beat is first burst sample; beats with tuser 1..3 pass gated.
REQ-008 TX: frame counter increments on accepted beat with tuser==3; on the beat completing frame burst_len, that beat is tagged last and FSM -> IDLE next cycle.
REQ-009 start while busy SHALL be ignored; burst_len changes after latch SHALL have no effect.
REQ-010 Beats accepted outside a burst (IDLE, ARM non-start beats) SHALL still pass through with output data 0, phase unchanged, tlast 0; stream is continuous.
REQ-011 Burst beat: product = signed 24-bit x * LUT value (48-bit), m_axis_tdata = product >>> 23, sign-extended to 32 bits (floor rounding, no saturation needed).
REQ-012 Pipeline SHALL be 2 stages (stage 1: LUT lookup + data/tuser/gate/last register; stage 2: multiply-shift register); latency 2 enable cycles input->output.
REQ-013 Pipeline enable en = !m_axis_tvalid || m_axis_tready; s_axis_tready = en; stage valids advance on en, bubbles propagate (tvalid 0 in -> valid 0 two stages later).
REQ-014 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tuser/tlast SHALL hold stable.
REQ-015 m_axis_tuser, m_axis_tlast SHALL be aligned with their m_axis_tdata.
REQ-016 busy SHALL fall the cycle after the tlast beat is accepted at the input, regardless of output drain.

Reset
REQ-017 Asserting s_axis_aresetn low SHALL immediately clear: FSM to IDLE, phases, frame counter, stage valids, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, busy=0.
REQ-018 Reset mid-burst SHALL abort the burst; no tlast emitted; first start after release begins a fresh burst with phases 0.

Verification
REQ-019 Constant x=1000 all channels, m_axis_tready=1, start with burst_len=2 -> each channel outputs 0, 587, then next burst frame: ch0 frame values 0 then 587; with burst_len=5 ch0 sequence 0, 587, -952, 951, -588.
REQ-020 start while tuser==2 in flight -> beats ch2, ch3 output 0, busy=1; burst begins on next ch0 beat.
REQ-021 burst_len=1 -> exactly 4 nonzero-gated beats, tlast=1 only on ch3 beat, busy low afterwards; following beats output 0.
REQ-022 Toggle m_axis_tready randomly during burst -> output sequence identical to ready=1 case, data stable while stalled, no drops/duplicates.
REQ-023 start with burst_len=0, and start while busy -> no state change, outputs 0.
REQ-024 Assert reset during TX frame 1 of burst_len=4 -> outputs cleared same cycle asynchronously, no tlast; new start after release yields ch0 sequence from phase 0.
